// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data extraction and retire counter.
// Optional last-writeback history for forwarding is built when WB_HISTORY_EN is defined.
module wb_stage #(
  parameter logic [31:0] RETIRE_INIT = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Stall_IN,
  input  logic        Flush_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] MemReadData_IN,
  input  logic        MemRead_IN,
  input  logic [1:0]  MemSize_IN,
  input  logic        MemSigned_IN,
  input  logic [1:0]  MemByteOffset_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        WriteEnable_IN,
  output logic [31:0] WriteData_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic        WriteEnable_OUT,
  output logic [31:0] RetireCount_OUT,
  output logic [31:0] HistData_OUT,
  output logic [4:0]  HistRegister_OUT,
  output logic        HistValid_OUT
);

  logic        valid_q,     valid_d;
  logic [31:0] alu_q,       alu_d;
  logic [31:0] mem_data_q,  mem_data_d;
  logic        mem_read_q,  mem_read_d;
  logic [1:0]  mem_size_q,  mem_size_d;
  logic        mem_sgn_q,   mem_sgn_d;
  logic [1:0]  mem_off_q,   mem_off_d;
  logic [4:0]  wreg_q,      wreg_d;
  logic        we_q,        we_d;
  logic [31:0] retire_q,    retire_d;

  // Little-endian sub-word select followed by sign or zero extension to 32 bits.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [1:0]  off
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = sgn ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      2'b01:   res = sgn ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // MEM/WB register next state: flush beats stall, stall holds everything.
  always_comb begin
    valid_d    = valid_q;
    alu_d      = alu_q;
    mem_data_d = mem_data_q;
    mem_read_d = mem_read_q;
    mem_size_d = mem_size_q;
    mem_sgn_d  = mem_sgn_q;
    mem_off_d  = mem_off_q;
    wreg_d     = wreg_q;
    we_d       = we_q;
    if (Flush_IN) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!Stall_IN) begin
      valid_d    = 1'b1;
      alu_d      = ALUResult_IN;
      mem_data_d = MemReadData_IN;
      mem_read_d = MemRead_IN;
      mem_size_d = MemSize_IN;
      mem_sgn_d  = MemSigned_IN;
      mem_off_d  = MemByteOffset_IN;
      wreg_d     = WriteRegister_IN;
      we_d       = WriteEnable_IN;
    end
  end

  // An instruction retires when it leaves the stage, i.e. valid and not held.
  always_comb begin
    retire_d = retire_q;
    if (valid_q && !Stall_IN) begin
      retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      mem_data_q <= '0;
      mem_read_q <= 1'b0;
      mem_size_q <= '0;
      mem_sgn_q  <= 1'b0;
      mem_off_q  <= '0;
      wreg_q     <= '0;
      we_q       <= 1'b0;
      retire_q   <= RETIRE_INIT;
    end else begin
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      mem_data_q <= mem_data_d;
      mem_read_q <= mem_read_d;
      mem_size_q <= mem_size_d;
      mem_sgn_q  <= mem_sgn_d;
      mem_off_q  <= mem_off_d;
      wreg_q     <= wreg_d;
      we_q       <= we_d;
      retire_q   <= retire_d;
    end
  end

  // Writeback outputs, combinational from the latched stage contents.
  always_comb begin
    WriteData_OUT     = mem_read_q ? load_extract(mem_data_q, mem_size_q, mem_sgn_q, mem_off_q)
                                   : alu_q;
    WriteRegister_OUT = wreg_q;
    WriteEnable_OUT   = valid_q && we_q && (wreg_q != 5'd0);
    RetireCount_OUT   = retire_q;
  end

`ifdef WB_HISTORY_EN
  logic [31:0] hist_data_q, hist_data_d;
  logic [4:0]  hist_reg_q,  hist_reg_d;
  logic        hist_vld_q,  hist_vld_d;

  // Capture whatever is actually committed to the register file this edge.
  always_comb begin
    hist_data_d = hist_data_q;
    hist_reg_d  = hist_reg_q;
    hist_vld_d  = hist_vld_q;
    if (!Stall_IN && WriteEnable_OUT) begin
      hist_data_d = WriteData_OUT;
      hist_reg_d  = WriteRegister_OUT;
      hist_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      hist_data_q <= '0;
      hist_reg_q  <= '0;
      hist_vld_q  <= 1'b0;
    end else begin
      hist_data_q <= hist_data_d;
      hist_reg_q  <= hist_reg_d;
      hist_vld_q  <= hist_vld_d;
    end
  end

  assign HistData_OUT     = hist_data_q;
  assign HistRegister_OUT = hist_reg_q;
  assign HistValid_OUT    = hist_vld_q;
`else
  assign HistData_OUT     = 32'h0000_0000;
  assign HistRegister_OUT = 5'd0;
  assign HistValid_OUT    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table through a scoreboard plus stall/flush/reset/history sequences.
module tb_wb_stage;

  logic        CLOCK;
  logic        RESET;
  logic        Stall_IN;
  logic        Flush_IN;
  logic [31:0] ALUResult_IN;
  logic [31:0] MemReadData_IN;
  logic        MemRead_IN;
  logic [1:0]  MemSize_IN;
  logic        MemSigned_IN;
  logic [1:0]  MemByteOffset_IN;
  logic [4:0]  WriteRegister_IN;
  logic        WriteEnable_IN;

  logic [31:0] wd, rc, h_wd;
  logic [4:0]  wr, h_wr;
  logic        we, h_v;
  logic [31:0] w_wd, w_rc, w_h_wd;
  logic [4:0]  w_wr, w_h_wr;
  logic        w_we, w_h_v;

  wb_stage dut (
    .CLOCK(CLOCK), .RESET(RESET), .Stall_IN(Stall_IN), .Flush_IN(Flush_IN),
    .ALUResult_IN(ALUResult_IN), .MemReadData_IN(MemReadData_IN), .MemRead_IN(MemRead_IN),
    .MemSize_IN(MemSize_IN), .MemSigned_IN(MemSigned_IN), .MemByteOffset_IN(MemByteOffset_IN),
    .WriteRegister_IN(WriteRegister_IN), .WriteEnable_IN(WriteEnable_IN),
    .WriteData_OUT(wd), .WriteRegister_OUT(wr), .WriteEnable_OUT(we), .RetireCount_OUT(rc),
    .HistData_OUT(h_wd), .HistRegister_OUT(h_wr), .HistValid_OUT(h_v)
  );

  // Second instance whose counter starts at all-ones so the wrap is reachable.
  wb_stage #(.RETIRE_INIT(32'hFFFF_FFFF)) u_wrap (
    .CLOCK(CLOCK), .RESET(RESET), .Stall_IN(Stall_IN), .Flush_IN(Flush_IN),
    .ALUResult_IN(ALUResult_IN), .MemReadData_IN(MemReadData_IN), .MemRead_IN(MemRead_IN),
    .MemSize_IN(MemSize_IN), .MemSigned_IN(MemSigned_IN), .MemByteOffset_IN(MemByteOffset_IN),
    .WriteRegister_IN(WriteRegister_IN), .WriteEnable_IN(WriteEnable_IN),
    .WriteData_OUT(w_wd), .WriteRegister_OUT(w_wr), .WriteEnable_OUT(w_we), .RetireCount_OUT(w_rc),
    .HistData_OUT(w_h_wd), .HistRegister_OUT(w_h_wr), .HistValid_OUT(w_h_v)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic        rd;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [4:0]  rg;
    logic        wen;
    logic [31:0] e_wd;
    logic [4:0]  e_rg;
    logic        e_we;
  } vec_t;

  typedef struct packed {
    logic [31:0] wd;
    logic [4:0]  rg;
    logic        we;
  } exp_t;

  vec_t        tbl [16];
  exp_t        sbq [$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rc;
  logic        m_valid;
  logic [31:0] rc_before;
  logic [31:0] e_hd;
  logic [4:0]  e_hr;
  logic        e_hv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    ALUResult_IN     = v.alu;
    MemReadData_IN   = v.mem;
    MemRead_IN       = v.rd;
    MemSize_IN       = v.size;
    MemSigned_IN     = v.sgn;
    MemByteOffset_IN = v.off;
    WriteRegister_IN = v.rg;
    WriteEnable_IN   = v.wen;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] r, input logic w);
    exp_t e;
    e.wd = d;
    e.rg = r;
    e.we = w;
    sbq.push_back(e);
  endtask

  // Advance one clock edge and track the expected retire count and valid bit.
  task automatic step();
    if (m_valid && !Stall_IN) exp_rc = exp_rc + 32'd1;
    if (Flush_IN) m_valid = 1'b0;
    else if (!Stall_IN) m_valid = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: scoreboard empty, got wd=%h", tag, wd);
    end else begin
      total--;
      e = sbq.pop_front();
      chk({tag, "_wd"}, wd, e.wd);
      chk({tag, "_reg"}, {27'd0, wr}, {27'd0, e.rg});
      chk({tag, "_we"}, {31'd0, we}, {31'd0, e.we});
      chk({tag, "_w_wd"}, w_wd, e.wd);
      chk({tag, "_w_we"}, {31'd0, w_we}, {31'd0, e.we});
    end
    chk({tag, "_rc"}, rc, exp_rc);
    chk({tag, "_wrap_rc"}, w_rc, exp_rc - 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    //           alu           mem           rd    size   sgn   off    reg    we    exp_wd        exp_reg exp_we
    tbl[0]  = '{32'h0,        32'h0,        1'b0, 2'b00, 1'b0, 2'd0, 5'd0,  1'b0, 32'h00000000, 5'd0,  1'b0};
    tbl[1]  = '{32'h12345678, 32'hAAAAAAAA, 1'b0, 2'b00, 1'b1, 2'd3, 5'd5,  1'b1, 32'h12345678, 5'd5,  1'b1};
    tbl[2]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b00, 1'b1, 2'd3, 5'd6,  1'b1, 32'hFFFFFF80, 5'd6,  1'b1};
    tbl[3]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b00, 1'b0, 2'd3, 5'd6,  1'b1, 32'h00000080, 5'd6,  1'b1};
    tbl[4]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b00, 1'b1, 2'd0, 5'd8,  1'b1, 32'h00000001, 5'd8,  1'b1};
    tbl[5]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b00, 1'b1, 2'd1, 5'd8,  1'b1, 32'h0000007F, 5'd8,  1'b1};
    tbl[6]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b00, 1'b1, 2'd2, 5'd8,  1'b1, 32'hFFFFFFFF, 5'd8,  1'b1};
    tbl[7]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b01, 1'b1, 2'd0, 5'd10, 1'b1, 32'h00007F01, 5'd10, 1'b1};
    tbl[8]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b01, 1'b1, 2'd2, 5'd10, 1'b1, 32'hFFFF80FF, 5'd10, 1'b1};
    tbl[9]  = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b01, 1'b0, 2'd3, 5'd10, 1'b1, 32'h000080FF, 5'd10, 1'b1};
    tbl[10] = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b01, 1'b1, 2'd1, 5'd10, 1'b1, 32'h00007F01, 5'd10, 1'b1};
    tbl[11] = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b10, 1'b1, 2'd2, 5'd12, 1'b1, 32'h80FF7F01, 5'd12, 1'b1};
    tbl[12] = '{32'h11111111, 32'h80FF7F01, 1'b1, 2'b11, 1'b1, 2'd1, 5'd12, 1'b1, 32'h80FF7F01, 5'd12, 1'b1};
    tbl[13] = '{32'hDEADBEEF, 32'h0,        1'b0, 2'b10, 1'b0, 2'd0, 5'd0,  1'b1, 32'hDEADBEEF, 5'd0,  1'b0};
    tbl[14] = '{32'h00000001, 32'h0,        1'b0, 2'b10, 1'b0, 2'd0, 5'd31, 1'b0, 32'h00000001, 5'd31, 1'b0};
    tbl[15] = '{32'hCAFEF00D, 32'h80FF7F01, 1'b0, 2'b00, 1'b1, 2'd3, 5'd17, 1'b1, 32'hCAFEF00D, 5'd17, 1'b1};

    RESET = 1'b0;
    Stall_IN = 1'b0;
    Flush_IN = 1'b0;
    apply(tbl[0]);
    exp_rc = 32'd0;
    m_valid = 1'b0;
    repeat (2) @(negedge CLOCK);

    // Reset state.
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_rc", rc, 32'd0);
    chk("rst_hv", {31'd0, h_v}, 32'd0);
    chk("rst_wrap_rc", w_rc, 32'hFFFF_FFFF);
    chk("rst_w_hv", {31'd0, w_h_v}, 32'd0);

    // Table of plain latches, one per cycle.
    RESET = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      push(tbl[i].e_wd, tbl[i].e_rg, tbl[i].e_we);
      step();
      check_out($sformatf("vec%0d", i));
    end

    // Stall hold: outputs and counter frozen while inputs move.
    rc_before = exp_rc;
    ALUResult_IN = 32'h0000_000A; MemRead_IN = 1'b0;
    WriteRegister_IN = 5'd9; WriteEnable_IN = 1'b1;
    push(32'h0000_000A, 5'd9, 1'b1);
    step();
    check_out("stall_latch");
    Stall_IN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ALUResult_IN = 32'h100 + k;
      WriteRegister_IN = 5'd20 + 5'(k);
      MemRead_IN = k[0];
      push(32'h0000_000A, 5'd9, 1'b1);
      step();
      check_out($sformatf("stall%0d", k));
    end
    chk("stall_rc_rise", rc, rc_before + 32'd1);
    Stall_IN = 1'b0;

    // Stall and flush together: flush wins, nothing retires on that edge.
    ALUResult_IN = 32'h77; MemRead_IN = 1'b0;
    WriteRegister_IN = 5'd7; WriteEnable_IN = 1'b1;
    push(32'h77, 5'd7, 1'b1);
    step();
    check_out("sf_latch");
    rc_before = exp_rc;
    Stall_IN = 1'b1; Flush_IN = 1'b1;
    ALUResult_IN = 32'h99; WriteRegister_IN = 5'd11;
    step();
    chk("sf_we", {31'd0, we}, 32'd0);
    chk("sf_rc", rc, rc_before);
    chk("sf_rc_model", rc, exp_rc);
    Stall_IN = 1'b0; Flush_IN = 1'b0;

    // History survives a flush and reflects the last committed write.
    ALUResult_IN = 32'h55; MemRead_IN = 1'b0;
    WriteRegister_IN = 5'd3; WriteEnable_IN = 1'b1;
    push(32'h55, 5'd3, 1'b1);
    step();
    check_out("hist_latch");
    Flush_IN = 1'b1;
    ALUResult_IN = 32'h66; WriteRegister_IN = 5'd4;
    step();
`ifdef WB_HISTORY_EN
    e_hd = 32'h55; e_hr = 5'd3; e_hv = 1'b1;
`else
    e_hd = 32'h0;  e_hr = 5'd0; e_hv = 1'b0;
`endif
    chk("hist_flush_we", {31'd0, we}, 32'd0);
    chk("hist_flush_rc", rc, exp_rc);
    chk("hist_data", h_wd, e_hd);
    chk("hist_reg", {27'd0, h_wr}, {27'd0, e_hr});
    chk("hist_valid", {31'd0, h_v}, {31'd0, e_hv});
    step();
    chk("hist_data_hold", h_wd, e_hd);
    chk("hist_reg_hold", {27'd0, h_wr}, {27'd0, e_hr});
    chk("hist_valid_hold", {31'd0, h_v}, {31'd0, e_hv});
    chk("w_hist_data", w_h_wd, e_hd);
    chk("w_hist_reg", {27'd0, w_h_wr}, {27'd0, e_hr});
    chk("w_hist_valid", {31'd0, w_h_v}, {31'd0, e_hv});
    Flush_IN = 1'b0;

    // Asynchronous reset in the middle of a stall+flush, then a normal latch.
    Stall_IN = 1'b1; Flush_IN = 1'b1;
    #2 RESET = 1'b0;
    #1;
    chk("arst_we", {31'd0, we}, 32'd0);
    chk("arst_wd", wd, 32'd0);
    chk("arst_rc", rc, 32'd0);
    chk("arst_hv", {31'd0, h_v}, 32'd0);
    chk("arst_wrap_rc", w_rc, 32'hFFFF_FFFF);
    @(negedge CLOCK);
    RESET = 1'b1;
    Stall_IN = 1'b0; Flush_IN = 1'b0;
    exp_rc = 32'd0; m_valid = 1'b0;
    ALUResult_IN = 32'h44; MemRead_IN = 1'b0;
    WriteRegister_IN = 5'd4; WriteEnable_IN = 1'b1;
    push(32'h44, 5'd4, 1'b1);
    step();
    check_out("post_rst");
    ALUResult_IN = 32'h45;
    push(32'h45, 5'd4, 1'b1);
    step();
    check_out("post_rst2");

    chk("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
